// File: rtl/atb_protocol_monitor.sv
// Passive ATB link monitor: sticky per-rule error flags, error pulse, beat/byte/flush counters.
// Results are registered one sample after the observed cycle; the monitor never drives or backpressures the link.
module atb_protocol_monitor #(
   parameter int DATA_WIDTH       = 32,
   parameter int BYTES_WIDTH      = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
   parameter int ID_WIDTH         = 7,
   parameter int CNT_WIDTH        = 16,
   parameter int MAX_STALL        = 256,
   parameter bit STRICT_IDLE_DATA = 1'b1
) (
   input  logic                   atclk,
   input  logic                   atreset,
   input  logic                   atclken,
   input  logic                   atvalid,
   input  logic                   atready,
   input  logic [DATA_WIDTH-1:0]  atdata,
   input  logic [BYTES_WIDTH-1:0] atbytes,
   input  logic [ID_WIDTH-1:0]    atid,
   input  logic                   afvalid,
   input  logic                   afready,
   input  logic                   clear,
   output logic [6:0]             err_flags,
   output logic                   err_pulse,
   output logic [CNT_WIDTH-1:0]   beat_count,
   output logic [CNT_WIDTH-1:0]   byte_count,
   output logic [CNT_WIDTH-1:0]   flush_count,
   output logic                   stalled
);

   localparam int                  SCW       = $clog2(MAX_STALL + 1);
   localparam int                  SW        = CNT_WIDTH + 1;
   localparam logic [SCW-1:0]      STALL_MAX = SCW'(MAX_STALL);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic {T_IDLE, T_STALL} xfer_state_e;
   typedef enum logic {F_IDLE, F_FLUSH} flush_state_e;

   xfer_state_e            xs_q, xs_d;
   flush_state_e           fs_q, fs_d;
   logic [SCW-1:0]         stall_cnt_q, stall_cnt_d;
   logic [DATA_WIDTH-1:0]  cap_data_q, cap_data_d;
   logic [BYTES_WIDTH-1:0] cap_bytes_q, cap_bytes_d;
   logic [ID_WIDTH-1:0]    cap_id_q, cap_id_d;
   logic [6:0]             err_flags_q, err_flags_d;
   logic                   err_pulse_q, err_pulse_d;
   logic [CNT_WIDTH-1:0]   beat_q, beat_d;
   logic [CNT_WIDTH-1:0]   byte_q, byte_d;
   logic [CNT_WIDTH-1:0]   flush_q, flush_d;
   logic [6:0]             err_new;
   logic [SW-1:0]          byte_sum;

   always_comb begin
      xs_d        = xs_q;
      fs_d        = fs_q;
      stall_cnt_d = stall_cnt_q;
      cap_data_d  = cap_data_q;
      cap_bytes_d = cap_bytes_q;
      cap_id_d    = cap_id_q;
      err_flags_d = err_flags_q;
      err_pulse_d = 1'b0;
      beat_d      = beat_q;
      byte_d      = byte_q;
      flush_d     = flush_q;
      err_new     = '0;
      byte_sum    = {1'b0, byte_q} + SW'(atbytes) + SW'(1);

      if (atclken) begin
         case (xs_q)
            T_IDLE: begin
               if (atvalid && !atready) begin
                  xs_d        = T_STALL;
                  cap_data_d  = atdata;
                  cap_bytes_d = atbytes;
                  cap_id_d    = atid;
                  stall_cnt_d = SCW'(1);
                  err_new[4]  = (STALL_MAX == SCW'(1));
               end
            end
            T_STALL: begin
               if (!atvalid) begin
                  xs_d       = T_IDLE;
                  err_new[0] = 1'b1;
               end else begin
                  err_new[1] = ({atdata, atbytes, atid} != {cap_data_q, cap_bytes_q, cap_id_q});
                  if (atready) begin
                     xs_d = T_IDLE;
                  end else if (stall_cnt_q != STALL_MAX) begin
                     // saturating at STALL_MAX keeps the timeout to one per episode
                     stall_cnt_d = stall_cnt_q + SCW'(1);
                     err_new[4]  = (stall_cnt_d == STALL_MAX);
                  end
               end
            end
         endcase

         err_new[2] = STRICT_IDLE_DATA && !atvalid && (atdata != '0);
         err_new[3] = atvalid && ((atid == '0) || (atid[ID_WIDTH-1 -: 3] == 3'b111));

         case (fs_q)
            F_IDLE: begin
               if (afvalid && afready) begin
                  flush_d = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_WIDTH'(1);
               end else if (afvalid) begin
                  fs_d = F_FLUSH;
               end else if (afready) begin
                  err_new[6] = 1'b1;
               end
            end
            F_FLUSH: begin
               if (!afvalid) begin
                  fs_d       = F_IDLE;
                  err_new[5] = 1'b1;
               end else if (afready) begin
                  fs_d    = F_IDLE;
                  flush_d = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_WIDTH'(1);
               end
            end
         endcase

         if (atvalid && atready) begin
            beat_d = (beat_q == CNT_MAX) ? beat_q : beat_q + CNT_WIDTH'(1);
            byte_d = byte_sum[CNT_WIDTH] ? CNT_MAX : byte_sum[CNT_WIDTH-1:0];
         end

         if (clear) begin
            err_flags_d = '0;
            beat_d      = '0;
            byte_d      = '0;
            flush_d     = '0;
            stall_cnt_d = '0;
         end else begin
            err_flags_d = err_flags_q | err_new;
            err_pulse_d = |(err_new & ~err_flags_q);
         end
      end
   end

   always_ff @(posedge atclk or posedge atreset) begin
      if (atreset) begin
         xs_q        <= T_IDLE;
         fs_q        <= F_IDLE;
         stall_cnt_q <= '0;
         cap_data_q  <= '0;
         cap_bytes_q <= '0;
         cap_id_q    <= '0;
         err_flags_q <= '0;
         err_pulse_q <= 1'b0;
         beat_q      <= '0;
         byte_q      <= '0;
         flush_q     <= '0;
      end else begin
         xs_q        <= xs_d;
         fs_q        <= fs_d;
         stall_cnt_q <= stall_cnt_d;
         cap_data_q  <= cap_data_d;
         cap_bytes_q <= cap_bytes_d;
         cap_id_q    <= cap_id_d;
         err_flags_q <= err_flags_d;
         err_pulse_q <= err_pulse_d;
         beat_q      <= beat_d;
         byte_q      <= byte_d;
         flush_q     <= flush_d;
      end
   end

   assign err_flags   = err_flags_q;
   assign err_pulse   = err_pulse_q;
   assign beat_count  = beat_q;
   assign byte_count  = byte_q;
   assign flush_count = flush_q;
   assign stalled     = (xs_q == T_STALL);

endmodule

// File: tb/tb_atb_protocol_monitor.sv
// Bench for atb_protocol_monitor: directed scenarios plus random traffic against a behavioural model.
// Two monitors watch the same link, one with the idle-data rule enabled and one without.
module tb_atb_protocol_monitor;
   localparam int DW = 32;
   localparam int BW = 2;
   localparam int IW = 7;
   localparam int CW = 8;
   localparam int MS = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic atclk = 1'b0;
   logic atreset, atclken, atvalid, atready, afvalid, afready, clear;
   logic [DW-1:0] atdata;
   logic [BW-1:0] atbytes;
   logic [IW-1:0] atid;
   logic [6:0]    err_flags, err_flags2;
   logic          err_pulse, err_pulse2, stalled, stalled2;
   logic [CW-1:0] beat_count, byte_count, flush_count, beat2, byte2, flush2;

   int checks = 0;
   int passed = 0;

   // behavioural model of the link as the rules describe it
   bit            m_stall, m_flush, m_pulse, m_pulse2;
   logic [DW-1:0] m_cd;
   logic [BW-1:0] m_cb;
   logic [IW-1:0] m_ci;
   int            m_scnt, m_beats, m_bytes, m_flushes;
   logic [6:0]    m_err, m_err2;

   atb_protocol_monitor #(.DATA_WIDTH(DW), .BYTES_WIDTH(BW), .ID_WIDTH(IW), .CNT_WIDTH(CW),
                          .MAX_STALL(MS), .STRICT_IDLE_DATA(1'b1)) dut (
      .atclk(atclk), .atreset(atreset), .atclken(atclken), .atvalid(atvalid), .atready(atready),
      .atdata(atdata), .atbytes(atbytes), .atid(atid), .afvalid(afvalid), .afready(afready),
      .clear(clear), .err_flags(err_flags), .err_pulse(err_pulse), .beat_count(beat_count),
      .byte_count(byte_count), .flush_count(flush_count), .stalled(stalled));

   atb_protocol_monitor #(.DATA_WIDTH(DW), .BYTES_WIDTH(BW), .ID_WIDTH(IW), .CNT_WIDTH(CW),
                          .MAX_STALL(MS), .STRICT_IDLE_DATA(1'b0)) dut2 (
      .atclk(atclk), .atreset(atreset), .atclken(atclken), .atvalid(atvalid), .atready(atready),
      .atdata(atdata), .atbytes(atbytes), .atid(atid), .afvalid(afvalid), .afready(afready),
      .clear(clear), .err_flags(err_flags2), .err_pulse(err_pulse2), .beat_count(beat2),
      .byte_count(byte2), .flush_count(flush2), .stalled(stalled2));

   always #5 atclk = ~atclk;

   function automatic logic [32:0] obs1();
      return {err_flags, err_pulse, stalled, beat_count, byte_count, flush_count};
   endfunction
   function automatic logic [32:0] obs2();
      return {err_flags2, err_pulse2, stalled2, beat2, byte2, flush2};
   endfunction
   function automatic logic [32:0] exp1();
      return {m_err, m_pulse, m_stall, CW'(m_beats), CW'(m_bytes), CW'(m_flushes)};
   endfunction
   function automatic logic [32:0] exp2();
      return {m_err2, m_pulse2, m_stall, CW'(m_beats), CW'(m_bytes), CW'(m_flushes)};
   endfunction
   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_reset();
      m_stall = 0; m_flush = 0; m_pulse = 0; m_pulse2 = 0;
      m_cd = '0; m_cb = '0; m_ci = '0;
      m_scnt = 0; m_beats = 0; m_bytes = 0; m_flushes = 0;
      m_err = '0; m_err2 = '0;
   endtask

   task automatic model_step();
      logic [6:0] nw;
      nw = '0;
      if (!atclken) begin
         m_pulse = 0; m_pulse2 = 0;
         return;
      end
      if (m_stall) begin
         if (!atvalid) begin
            nw[0] = 1'b1; m_stall = 0;
         end else begin
            if (atdata != m_cd || atbytes != m_cb || atid != m_ci) nw[1] = 1'b1;
            if (atready) m_stall = 0;
            else if (m_scnt < MS) begin
               m_scnt++;
               if (m_scnt == MS) nw[4] = 1'b1;
            end
         end
      end else if (atvalid && !atready) begin
         m_stall = 1; m_cd = atdata; m_cb = atbytes; m_ci = atid; m_scnt = 1;
      end
      if (!atvalid && atdata != 0) nw[2] = 1'b1;
      if (atvalid && (atid == 0 || atid >= 7'h70)) nw[3] = 1'b1;
      if (!m_flush) begin
         if (afvalid && afready) m_flushes = sat(m_flushes + 1);
         else if (afvalid) m_flush = 1;
         else if (afready) nw[6] = 1'b1;
      end else if (!afvalid) begin
         nw[5] = 1'b1; m_flush = 0;
      end else if (afready) begin
         m_flushes = sat(m_flushes + 1); m_flush = 0;
      end
      if (atvalid && atready) begin
         m_beats = sat(m_beats + 1);
         m_bytes = sat(m_bytes + int'(atbytes) + 1);
      end
      if (clear) begin
         m_err = '0; m_err2 = '0; m_pulse = 0; m_pulse2 = 0;
         m_beats = 0; m_bytes = 0; m_flushes = 0; m_scnt = 0;
      end else begin
         m_pulse  = |(nw & ~m_err);
         m_err    = m_err | nw;
         m_pulse2 = |(nw & 7'h7B & ~m_err2);
         m_err2   = m_err2 | (nw & 7'h7B);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge atclk);
      #1;
   endtask

   task automatic idle_inputs();
      atclken = 1; atvalid = 0; atready = 0; atdata = '0; atbytes = '0; atid = '0;
      afvalid = 0; afready = 0; clear = 0;
   endtask

   task automatic do_clear();
      clear = 1; tick(); clear = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      atreset = 1;
      model_reset();
      #3;
      checks++; if (obs1() !== 33'h0) $display("FAIL reset_state: got %h want 0", obs1()); else passed++;
      checks++; if (obs2() !== 33'h0) $display("FAIL reset_state2: got %h want 0", obs2()); else passed++;
      @(posedge atclk); #1; atreset = 0;
      tick();
      checks++; if (obs1() !== exp1()) $display("FAIL post_reset: got %h want %h", obs1(), exp1()); else passed++;
   endtask

   task automatic test_back_to_back();
      atvalid = 1; atready = 1; atbytes = 2'd3; atid = 7'h10;
      for (int i = 0; i < 10; i++) begin
         atdata = $urandom;
         tick();
      end
      atvalid = 0; atready = 0; atdata = '0;
      checks++; if (beat_count !== 8'd10) $display("FAIL b2b_beats: got %0d want 10", beat_count); else passed++;
      checks++; if (byte_count !== 8'd40) $display("FAIL b2b_bytes: got %0d want 40", byte_count); else passed++;
      checks++; if (err_flags !== 7'h00) $display("FAIL b2b_errs: got %h want 00", err_flags); else passed++;
      checks++; if (obs1() !== exp1()) $display("FAIL b2b_model: got %h want %h", obs1(), exp1()); else passed++;
   endtask

   task automatic test_payload_change();
      do_clear();
      atvalid = 1; atready = 0; atid = 7'h21; atbytes = 2'd2; atdata = 32'h1234_5678;
      tick();
      checks++; if ({stalled, err_flags} !== 8'h80) $display("FAIL pc_first: got %h want 80", {stalled, err_flags}); else passed++;
      atdata = 32'h1234_5679;
      tick();
      checks++; if ({err_pulse, err_flags} !== 8'h82) $display("FAIL pc_flag: got %h want 82", {err_pulse, err_flags}); else passed++;
      tick();
      checks++; if ({err_pulse, stalled} !== 2'b01) $display("FAIL pc_hold: got %b want 01", {err_pulse, stalled}); else passed++;
      atready = 1;
      tick();
      checks++; if ({stalled, beat_count} !== 9'd1) $display("FAIL pc_accept: got %h want 001", {stalled, beat_count}); else passed++;
      checks++; if (obs1() !== exp1()) $display("FAIL pc_model: got %h want %h", obs1(), exp1()); else passed++;
      atvalid = 0; atready = 0; atdata = '0;
   endtask

   task automatic test_stall_timeout();
      int pulses;
      pulses = 0;
      do_clear();
      atvalid = 1; atready = 0; atid = 7'h05; atbytes = 2'd1; atdata = 32'hA5A5_0001;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (err_pulse) pulses++;
         if (i == 2) begin
            checks++; if (err_flags !== 7'h00) $display("FAIL to_early: got %h want 00", err_flags); else passed++;
         end
         if (i == 3) begin
            checks++; if (err_flags !== 7'h10) $display("FAIL to_fire: got %h want 10", err_flags); else passed++;
         end
      end
      atready = 1;
      tick();
      if (err_pulse) pulses++;
      checks++; if (pulses !== 1) $display("FAIL to_once: got %0d pulses want 1", pulses); else passed++;
      checks++; if ({stalled, err_flags} !== 8'h10) $display("FAIL to_exit: got %h want 10", {stalled, err_flags}); else passed++;
      atvalid = 0; atready = 0;
      do_clear();
      atvalid = 1;
      repeat (3) tick();
      atready = 1;
      tick();
      checks++; if ({stalled, err_flags} !== 8'h00) $display("FAIL to_accept_at_limit: got %h want 00", {stalled, err_flags}); else passed++;
      atvalid = 0; atready = 0; atdata = '0;
   endtask

   task automatic test_idle_data_and_ids();
      do_clear();
      atdata = 32'hDEAD_BEEF;
      tick();
      checks++; if ({err_pulse, err_flags} !== 8'h84) $display("FAIL idle_strict: got %h want 84", {err_pulse, err_flags}); else passed++;
      checks++; if ({err_pulse2, err_flags2} !== 8'h00) $display("FAIL idle_lenient: got %h want 00", {err_pulse2, err_flags2}); else passed++;
      atdata = '0;
      do_clear();
      atvalid = 1; atready = 1; atid = 7'h72; atbytes = 2'd0; atdata = $urandom;
      tick();
      checks++; if ({err_flags, err_flags2} !== 14'h0408) $display("FAIL rsv_id72: got %h want 0408", {err_flags, err_flags2}); else passed++;
      do_clear();
      atid = 7'h00;
      tick();
      checks++; if (err_flags !== 7'h08) $display("FAIL rsv_id0: got %h want 08", err_flags); else passed++;
      atid = 7'h6F;
      do_clear();
      tick();
      checks++; if (err_flags !== 7'h00) $display("FAIL id6f_ok: got %h want 00", err_flags); else passed++;
      idle_inputs();
      tick();
   endtask

   task automatic test_flush();
      do_clear();
      afvalid = 1;
      repeat (4) tick();
      afready = 1;
      tick();
      checks++; if ({flush_count, err_flags} !== 15'h0080) $display("FAIL flush_done: got %h want 0080", {flush_count, err_flags}); else passed++;
      afvalid = 0; afready = 0;
      tick();
      afvalid = 1;
      repeat (2) tick();
      afvalid = 0;
      tick();
      checks++; if ({flush_count, err_flags} !== 15'h00A0) $display("FAIL flush_drop: got %h want 00a0", {flush_count, err_flags}); else passed++;
      do_clear();
      afvalid = 1; afready = 1;
      tick();
      afvalid = 0; afready = 0;
      checks++; if ({flush_count, err_flags} !== 15'h0080) $display("FAIL flush_same_cycle: got %h want 0080", {flush_count, err_flags}); else passed++;
      afready = 1;
      tick();
      afready = 0;
      checks++; if ({err_pulse, err_flags} !== 8'hC0) $display("FAIL spurious_afready: got %h want c0", {err_pulse, err_flags}); else passed++;
   endtask

   task automatic test_clken_and_reset();
      do_clear();
      atvalid = 1; atready = 0; atid = 7'h11; atdata = 32'h0000_0042;
      tick();
      atclken = 0;
      repeat (1000) tick();
      atclken = 1;
      checks++; if ({stalled, err_pulse, err_flags} !== 9'h100) $display("FAIL clken_hold: got %h want 100", {stalled, err_pulse, err_flags}); else passed++;
      repeat (2) tick();
      atready = 1;
      tick();
      checks++; if ({stalled, err_flags} !== 8'h00) $display("FAIL clken_accept: got %h want 00", {stalled, err_flags}); else passed++;
      atready = 0; atid = 7'h00;
      repeat (2) tick();
      checks++; if (obs1() !== exp1()) $display("FAIL pre_reset: got %h want %h", obs1(), exp1()); else passed++;
      #2 atreset = 1;
      #1;
      checks++; if (obs1() !== 33'h0) $display("FAIL mid_stall_reset: got %h want 0", obs1()); else passed++;
      model_reset();
      idle_inputs();
      @(posedge atclk); #1; atreset = 0;
      tick();
      checks++; if (obs1() !== exp1()) $display("FAIL after_reset: got %h want %h", obs1(), exp1()); else passed++;
   endtask

   task automatic test_clear();
      atvalid = 1; atready = 1; atid = 7'h00; atbytes = 2'd1;
      repeat (3) tick();
      atvalid = 0; atdata = 32'h1;
      afready = 1;
      tick();
      idle_inputs();
      checks++; if (obs1() !== exp1()) $display("FAIL pre_clear: got %h want %h", obs1(), exp1()); else passed++;
      do_clear();
      checks++; if ({err_flags, beat_count, byte_count, flush_count} !== 31'h0) $display("FAIL clear_all: got %h want 0", {err_flags, beat_count, byte_count, flush_count}); else passed++;
   endtask

   task automatic test_saturation();
      do_clear();
      atvalid = 1; atready = 1; atbytes = 2'd3; atid = 7'h10;
      repeat (70) tick();
      idle_inputs();
      checks++; if ({beat_count, byte_count} !== {8'd70, 8'd255}) $display("FAIL saturate: got %h want 46ff", {beat_count, byte_count}); else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         atclken = ($urandom_range(0, 9) != 0);
         clear   = ($urandom_range(0, 49) == 0);
         atvalid = ($urandom_range(0, 3) != 0);
         atready = ($urandom_range(0, 2) == 0);
         if (!m_stall || $urandom_range(0, 7) == 0) begin
            atdata  = $urandom;
            atbytes = BW'($urandom_range(0, 3));
            atid    = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(0, 127)) : IW'($urandom_range(1, 111));
         end
         if (!atvalid) atdata = ($urandom_range(0, 3) == 0) ? $urandom : '0;
         afvalid = ($urandom_range(0, 2) == 0);
         afready = ($urandom_range(0, 3) == 0);
         tick();
         checks++; if (obs1() !== exp1()) $display("FAIL rand_strict cyc %0d: got %h want %h", i, obs1(), exp1()); else passed++;
         checks++; if (obs2() !== exp2()) $display("FAIL rand_lenient cyc %0d: got %h want %h", i, obs2(), exp2()); else passed++;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_payload_change();
      test_stall_timeout();
      test_idle_data_and_ids();
      test_flush();
      test_clken_and_reset();
      test_clear();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/atb_protocol_monitor.md
Name: atb_protocol_monitor

Overview:
Parametrised, synthesizable ATB protocol monitor that passively observes one ATB link.
- Registers sticky error flags per rule, plus a one-cycle error pulse.
- Counts accepted beats, accepted bytes and completed flushes.
- Sits beside any ATB source/sink pair in the trace fabric or VIP top.
- Generalises the fixed-width, single-rule idle-data check to configurable widths and a full rule set: handshake stability, stall timeout, reserved IDs, flush handshake.

Parameters:
DATA_WIDTH, 32, atdata width in bits; must be 8*2^n with n>=0.
BYTES_WIDTH, $clog2(DATA_WIDTH/8) (min 1), atbytes width.
ID_WIDTH, 7, atid width; must be >=3.
CNT_WIDTH, 16, width of every counter.
MAX_STALL, 256, consecutive stalled sampled cycles that raise a timeout; must be >=1.
STRICT_IDLE_DATA, 1, when 1 the idle-data rule is enabled.

Ports:
atclk  input  1  monitor clock
atreset  input  1  asynchronous reset, active-high
atclken  input  1  sample enable; monitor state advances only when 1
atvalid  input  1  observed ATVALID
atready  input  1  observed ATREADY
atdata  input  DATA_WIDTH  observed ATDATA
atbytes  input  BYTES_WIDTH  observed ATBYTES (valid bytes minus 1)
atid  input  ID_WIDTH  observed ATID
afvalid  input  1  observed flush request
afready  input  1  observed flush acknowledge
clear  input  1  synchronous clear of errors and counters
err_flags  output  7  sticky error vector, bit map below
err_pulse  output  1  high one cycle when any error bit newly sets
beat_count  output  CNT_WIDTH  accepted beats, saturating
byte_count  output  CNT_WIDTH  accepted bytes, saturating
flush_count  output  CNT_WIDTH  completed flushes, saturating
stalled  output  1  high while transfer FSM is in STALL

Behaviour:
- Reset (async, atreset=1): all outputs 0; both FSMs IDLE; stall counter 0; captured payload 0.
- Sample: a posedge atclk with atclken=1. Non-sample edges hold all state; err_pulse forced 0.
- clear on a sample: zeroes err_flags, all counters and the stall counter; FSMs keep their state. Errors detected in the same sample are discarded.
- Accept: atvalid&atready on a sample.
  - beat_count += 1.
  - byte_count += atbytes+1.
  - Both saturate at all-ones, no wrap.
- Transfer FSM:
  - IDLE -> STALL when atvalid&!atready. Capture atdata, atbytes, atid; stall counter = 1.
  - STALL -> IDLE on accept.
  - STALL -> IDLE when atvalid=0; raises VALID_DROP.
  - STALL -> STALL otherwise; stall counter increments, saturating at MAX_STALL.
- Error bits (set registered, visible the cycle after the violating sample):
  - bit0 VALID_DROP: atvalid=0 while in STALL.
  - bit1 PAYLOAD_CHANGE: in STALL with atvalid=1 and atdata/atbytes/atid differ from the captured values.
  - bit2 IDLE_DATA: STRICT_IDLE_DATA=1, atvalid=0 and atdata!=0.
  - bit3 RESERVED_ID: atvalid=1 and (atid==0 or atid[ID_WIDTH-1 -: 3]==3'b111).
  - bit4 STALL_TIMEOUT: stall counter reaches MAX_STALL in STALL. Fires once per stall episode.
  - bit5 FLUSH_DROP: afvalid deasserts while flush FSM is in FLUSH before afready.
  - bit6 SPURIOUS_AFREADY: afready=1 while flush FSM is IDLE and afvalid=0.
- Flush FSM:
  - IDLE -> FLUSH when afvalid=1 and afready=0.
  - afvalid&afready from IDLE (same-cycle completion) or from FLUSH: flush_count += 1, state IDLE.
  - FLUSH -> IDLE when afvalid=0 (FLUSH_DROP).
- err_pulse = 1 for exactly one cycle after a sample where any err_flags bit goes 0->1. Multiple simultaneous new bits give one pulse.
- Simultaneous cases:
  - Accept on the same sample the counter would reach MAX_STALL: no timeout.
  - VALID_DROP and IDLE_DATA may set together.

Test Plan:
- Reset then 10 back-to-back accepts, atbytes=3, atid=0x10 -> beat_count=10, byte_count=40, err_flags=0.
- atvalid=1, atready=0 for 3 samples, atdata changed on 2nd -> err_flags=0x02, err_pulse one cycle, stalled=1 until accept.
- MAX_STALL=4, stall 4 samples then accept -> bit4 set exactly once. Stall 3 then accept -> no error.
- atvalid=0, atdata=0xDEADBEEF -> bit2 set. Repeat with STRICT_IDLE_DATA=0 -> no error. atid=0x72 valid -> bit3 set.
- afvalid high 5 cycles, afready on 5th -> flush_count=1. afvalid dropped early -> bit5. Lone afready pulse -> bit6.
- atclken=0 during a stall of 1000 cycles -> no timeout. Assert atreset mid-stall -> all outputs 0 immediately. clear after errors -> err_flags=0, counters=0.
